// File: rtl/mkt_pkg.sv
// Shared types and tick-word layout for the synthetic market-data source.
// Latency: n/a (types, constants and a pure packing function only).
// Backpressure: n/a.
package mkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } tick_state_t;

    // Tick word field placement
    localparam int TICK_SEQ_LSB   = 24;
    localparam int TICK_SEQ_W     = 8;
    localparam int TICK_DELTA_LSB = 20;
    localparam int TICK_DELTA_W   = 4;
    localparam int TICK_DIR_BIT   = 19;
    localparam int TICK_PRICE_LSB = 0;
    localparam int TICK_PRICE_W   = 16;

    // Galois feedback taps (x^32 + x^22 + x^2 + x + 1), right-shifting form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Packs one tick; bits [18:16] are left at zero.
    function automatic logic [31:0] make_tick(
        input logic [7:0]  seq,
        input logic [3:0]  delta,
        input logic        dir,
        input logic [15:0] price
    );
        logic [31:0] w;
        w = '0;
        w[TICK_SEQ_LSB   +: TICK_SEQ_W]   = seq;
        w[TICK_DELTA_LSB +: TICK_DELTA_W] = delta;
        w[TICK_DIR_BIT]                   = dir;
        w[TICK_PRICE_LSB +: TICK_PRICE_W] = price;
        return w;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR supplying the random-walk entropy.
// Latency: new value visible the cycle after advance is high.
// Backpressure: holds its state whenever advance is low.
module lfsr32
    import mkt_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [31:0] q
);

    // An all-zero seed would lock the register up, so substitute 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Next state: shift right, fold the taps in when the bit shifted out is 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
        end
    end

    // State register with synchronous active-low reset to the seed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/market_tick_gen.sv
// Random-walk price tick generator driving a 32-bit Avalon-ST source.
// Latency: step in IDLE -> GEN next cycle -> valid the cycle after; auto period RATE_DIV.
// Backpressure: valid/data held while ready=0 (stall_cnt counts); ready feeds registers only.
module market_tick_gen
    import mkt_pkg::*;
#(
    parameter int unsigned RATE_DIV   = 50_000_000,
    parameter logic [15:0] PRICE_INIT = 16'd10000,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        step,
    input  logic [3:0]  step_mag,
    output logic [31:0] data_out,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] seq_num,
    output logic [15:0] stall_cnt
);

    // WAIT length plus the GEN and SEND cycles gives exactly RATE_DIV per tick.
    localparam logic [31:0] WAIT_LOAD = 32'(RATE_DIV - 3);

    tick_state_t state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] price_q, price_d;
    logic [31:0] cnt_q, cnt_d;

    logic        lfsr_adv;
    logic [31:0] lfsr_val;
    logic        lfsr_unused;

    logic [3:0]  delta;
    logic        dir;
    logic [16:0] up17;
    logic [16:0] dn17;
    logic [15:0] price_next;

    lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (lfsr_adv),
        .q       (lfsr_val)
    );

    // Only the low five LFSR bits shape a step.
    assign lfsr_unused = ^lfsr_val[31:5];

    // Step size/direction from the current LFSR value, clamped to [1, 16'hFFFF].
    always_comb begin
        delta      = lfsr_val[3:0] & step_mag;
        dir        = (delta != 4'd0) ? lfsr_val[4] : 1'b0;
        up17       = {1'b0, price_q} + {13'd0, delta};
        dn17       = {1'b0, price_q} - {13'd0, delta};
        price_next = price_q;
        if (dir) begin
            price_next = up17[16] ? 16'hFFFF : up17[15:0];
        end else begin
            price_next = (dn17[16] || (dn17[15:0] == 16'd0)) ? 16'd1 : dn17[15:0];
        end
    end

    // FSM next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        valid_d  = valid_q;
        seq_d    = seq_q;
        stall_d  = stall_q;
        price_d  = price_q;
        cnt_d    = cnt_q;
        lfsr_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable || step) begin
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                lfsr_adv = 1'b1;
                price_d  = price_next;
                data_d   = make_tick(seq_q[7:0], delta, dir, price_next);
                valid_d  = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ready) begin
                    valid_d = 1'b0;
                    seq_d   = seq_q + 16'd1;
                    if (enable) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 32'd0) begin
                    state_d = ST_GEN;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any tick in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
            seq_q   <= 16'd0;
            stall_q <= 16'd0;
            price_q <= PRICE_INIT;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            seq_q   <= seq_d;
            stall_q <= stall_d;
            price_q <= price_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign seq_num   = seq_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_market_tick_gen.sv
module tb_market_tick_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: short auto-run period, default price and seed
    logic        rst_a, en_a, step_a, valid_a, rdy_a;
    logic [3:0]  mag_a;
    logic [31:0] data_a;
    logic [15:0] seq_a, stall_a;

    // Instance B: starts near the ceiling, fastest legal period
    logic        rst_b, en_b, step_b, valid_b, rdy_b;
    logic [3:0]  mag_b;
    logic [31:0] data_b;
    logic [15:0] seq_b, stall_b;

    market_tick_gen #(.RATE_DIV(10)) u_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .step(step_a), .step_mag(mag_a),
        .data_out(data_a), .valid(valid_a), .ready(rdy_a),
        .seq_num(seq_a), .stall_cnt(stall_a)
    );

    market_tick_gen #(.RATE_DIV(3), .PRICE_INIT(16'hFFFE)) u_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .step(step_b), .step_mag(mag_b),
        .data_out(data_b), .valid(valid_b), .ready(rdy_b),
        .seq_num(seq_b), .stall_cnt(stall_b)
    );

    int ncomp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int hi;
        int pm;
        int sm;
        int bad_dir;
        int bad_range;
        logic [31:0] lm;
        logic [31:0] expw;
        logic [3:0]  d;
        logic        dr;

        rst_a = 1'b0; en_a = 1'b0; step_a = 1'b0; mag_a = 4'h0; rdy_a = 1'b1;
        rst_b = 1'b0; en_b = 1'b0; step_b = 1'b0; mag_b = 4'hF; rdy_b = 1'b1;

        // Reset held three cycles
        repeat (3) tick();
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_data",  data_a, 32'd0);
        chk("rst_seq",   {16'd0, seq_a}, 32'd0);
        chk("rst_stall", {16'd0, stall_a}, 32'd0);
        rst_a = 1'b1;
        tick();

        // Single step, zero magnitude, ready high
        step_a = 1'b1; tick(); step_a = 1'b0;
        chk("step_gen_valid", {31'd0, valid_a}, 32'd0);
        tick();
        chk("step_valid", {31'd0, valid_a}, 32'd1);
        chk("step_data",  data_a, 32'h0000_2710);
        tick();
        chk("step_seq",        {16'd0, seq_a}, 32'd1);
        chk("step_valid_drop", {31'd0, valid_a}, 32'd0);

        // Backpressure: five stalled cycles then acceptance
        rdy_a = 1'b0; step_a = 1'b1; tick(); step_a = 1'b0; tick();
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", {31'd0, valid_a}, 32'd1);
            chk("bp_data",  data_a, 32'h0100_2710);
            if (i == 5) rdy_a = 1'b1;
            tick();
        end
        chk("bp_valid_drop", {31'd0, valid_a}, 32'd0);
        chk("bp_stall",      {16'd0, stall_a}, 32'd5);
        chk("bp_seq",        {16'd0, seq_a}, 32'd2);
        tick();
        chk("bp_no_repeat",  {31'd0, valid_a}, 32'd0);

        // Auto-run from a fresh reset: one accept every 10 cycles
        rst_a = 1'b0; tick(); rst_a = 1'b1; en_a = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (valid_a !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
            chk("auto_wait", {31'd0, valid_a}, 32'd1);
            if (t > 0) chk("auto_gap", n, 32'd9);
            chk("auto_data", data_a, {t[7:0], 24'h00_2710});
            tick();
        end
        en_a = 1'b0;
        chk("auto_seq", {16'd0, seq_a}, 32'd4);
        hi = 0;
        repeat (30) begin
            tick();
            if (valid_a) hi++;
        end
        chk("auto_stop", hi, 32'd0);

        // Reset in the middle of a stalled SEND
        rdy_a = 1'b0; step_a = 1'b1; tick(); step_a = 1'b0; tick();
        chk("ms_valid", {31'd0, valid_a}, 32'd1);
        chk("ms_data",  data_a, 32'h0400_2710);
        step_a = 1'b1; tick(); step_a = 1'b0; tick();
        chk("ms_stall", {16'd0, stall_a}, 32'd2);
        rst_a = 1'b0; tick(); rst_a = 1'b1;
        chk("ms_valid_drop", {31'd0, valid_a}, 32'd0);
        chk("ms_seq",        {16'd0, seq_a}, 32'd0);
        chk("ms_stall_clr",  {16'd0, stall_a}, 32'd0);
        chk("ms_data_clr",   data_a, 32'd0);

        // A step arriving during SEND must not queue a second tick
        step_a = 1'b1; tick(); step_a = 1'b0; tick();
        chk("ign_data", data_a, 32'h0000_2710);
        step_a = 1'b1; tick(); step_a = 1'b0;
        rdy_a = 1'b1; tick();
        hi = 0;
        repeat (10) begin
            if (valid_a) hi++;
            tick();
        end
        chk("ign_extra", hi, 32'd0);
        chk("ign_seq",   {16'd0, seq_a}, 32'd1);

        // Clamp run: 2000 ticks against a reference random walk
        rst_b = 1'b1; en_b = 1'b1;
        lm = 32'hACE1_2468;
        pm = 32'h0000_FFFE;
        sm = 0;
        bad_dir = 0;
        bad_range = 0;
        for (int k = 0; k < 2000; k++) begin
            n = 0;
            while (valid_b !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            chk("clamp_wait", {31'd0, valid_b}, 32'd1);
            d  = lm[3:0] & 4'hF;
            dr = (d != 4'd0) ? lm[4] : 1'b0;
            if (dr) begin
                pm = pm + int'(d);
                if (pm > 65535) pm = 65535;
            end else begin
                pm = pm - int'(d);
                if (pm < 1) pm = 1;
            end
            expw = {sm[7:0], d, dr, 3'b000, pm[15:0]};
            chk("clamp_tick", data_b, expw);
            if (data_b[23:20] == 4'd0 && data_b[19]) bad_dir++;
            if (data_b[15:0] == 16'd0) bad_range++;
            lm = lm[0] ? ((lm >> 1) ^ 32'h8020_0003) : (lm >> 1);
            sm++;
            tick();
        end
        chk("clamp_dir_rule", bad_dir, 32'd0);
        chk("clamp_range",    bad_range, 32'd0);
        chk("clamp_seq",      {16'd0, seq_b}, 32'd2000);
        chk("clamp_stall",    {16'd0, stall_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
